vga_rgb_prefetch: RTL and testbench

Downstream consumer of the decoded RGB image in external SRAM. Once decoding finishes, it streams the 320x240 RGB frame out of SRAM and feeds the VGA output path one 24-bit pixel per request. It sits between the SRAM controller's read port and the VGA pixel generator.
- Packing: 3 SRAM words per 2 pixels, {R0,G0},{B0,R1},{G1,B1}.
- Buffering: a small word FIFO hides the SRAM read latency.

---
 rtl/vga_rgb_pkg.sv | 14 +
 rtl/rgb_word_fifo.sv | 45 ++++
 rtl/vga_rgb_prefetch.sv | 149 ++++++++++++++
 tb/tb_vga_rgb_prefetch.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_rgb_pkg.sv
// Shared types and frame constants for the RGB prefetch path between the
// SRAM read port and the VGA pixel generator.
package vga_rgb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    localparam int RGB_WORDS_PER_FRAME = 115200;
    localparam int PIXELS_PER_FRAME    = 76800;

endpackage

// File: rtl/rgb_word_fifo.sv
// Word FIFO with a two-entry peek so an even pixel can take both of its
// words in a single cycle.
module rgb_word_fifo
#(
    parameter int DEPTH = 8
) (
    input  logic                     Clock_50,
    input  logic                     Reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [15:0]              din,
    input  logic [1:0]               pop_n,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              dout0,
    output logic [15:0]              dout1
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][15:0] mem;
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    assign dout0 = mem[rd_ptr];
    assign dout1 = mem[rd_ptr + AW'(1)];

    // NOTE: state uses <= so every register samples pre-edge values; the
    // storage is cleared too, so the peek outputs never show stale words.
    always_ff @(posedge Clock_50) begin
        if (Reset || clear) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr + AW'(pop_n);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop_n);
        end
    end

endmodule

// File: rtl/vga_rgb_prefetch.sv
// Streams the packed RGB frame out of SRAM (3 words per 2 pixels) and serves
// one 24-bit pixel per Pixel_req, using a small FIFO to hide read latency.
module vga_rgb_prefetch
    import vga_rgb_pkg::*;
#(
    parameter int SRAM_LATENCY = 2,
    parameter int FIFO_DEPTH   = 8,
    parameter int FRAME_PIXELS = PIXELS_PER_FRAME
) (
    input  logic        Clock_50,
    input  logic        Reset,
    input  logic        Start,
    input  logic [17:0] Base_address,
    input  logic [15:0] SRAM_read_data,
    output logic [17:0] SRAM_address,
    output logic        SRAM_we_n,
    input  logic        Pixel_req,
    output logic        Pixel_valid,
    output logic [7:0]  Pixel_R,
    output logic [7:0]  Pixel_G,
    output logic [7:0]  Pixel_B,
    output logic        Busy,
    output logic        Frame_done,
    output logic        Underflow
);

    localparam int FRAME_WORDS = (FRAME_PIXELS / 2) * (RGB_WORDS_PER_FRAME / (PIXELS_PER_FRAME / 2));
    localparam int CW          = $clog2(FIFO_DEPTH) + 1;
    localparam int VW          = SRAM_LATENCY + 1;

    state_t          state, state_next;
    logic [17:0]     base_q;
    logic [16:0]     word_cnt;
    logic [16:0]     pix_cnt;
    logic [VW-1:0]   vld;       // bit 0 aligns with SRAM_address, top bit with SRAM_read_data
    logic            phase;
    logic [7:0]      residue;
    logic [CW-1:0]   occ;
    logic [15:0]     w0, w1;
    logic            start_ok, issue, serve, have_words, last_pixel;
    logic [1:0]      pop_n;

    assign SRAM_we_n = 1'b1;
    assign Busy      = (state != S_IDLE);

    rgb_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .Clock_50 (Clock_50),
        .Reset    (Reset),
        .clear    (start_ok),
        .push     (vld[SRAM_LATENCY]),
        .din      (SRAM_read_data),
        .pop_n    (pop_n),
        .count    (occ),
        .dout0    (w0),
        .dout1    (w1)
    );

    always_ff @(posedge Clock_50) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        issue      = 1'b0;
        serve      = 1'b0;
        last_pixel = 1'b0;
        pop_n      = 2'd0;
        have_words = phase ? (occ >= CW'(1)) : (occ >= CW'(2));
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_ok   = 1'b1;
                    issue      = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_FETCH, S_DRAIN: begin
                serve = Pixel_req;
                // In-flight words are counted so the FIFO can never overflow.
                if (state == S_FETCH && (int'(occ) + $countones(vld)) < FIFO_DEPTH) begin
                    issue = 1'b1;
                    if (word_cnt == 17'(FRAME_WORDS - 1)) state_next = S_DRAIN;
                end
                if (Pixel_req && have_words) pop_n = phase ? 2'd1 : 2'd2;
                if (state == S_DRAIN && Pixel_req && pix_cnt == 17'(FRAME_PIXELS - 1)) begin
                    last_pixel = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            base_q       <= '0;
            word_cnt     <= '0;
            pix_cnt      <= '0;
            vld          <= '0;
            phase        <= 1'b0;
            residue      <= '0;
            SRAM_address <= '0;
            Pixel_valid  <= 1'b0;
            Pixel_R      <= '0;
            Pixel_G      <= '0;
            Pixel_B      <= '0;
            Frame_done   <= 1'b0;
            Underflow    <= 1'b0;
        end else begin
            Pixel_valid <= serve;
            Frame_done  <= last_pixel;
            // A new frame discards anything still in flight from the last one.
            vld <= start_ok ? VW'(1) : {vld[SRAM_LATENCY-1:0], issue};
            if (start_ok) begin
                base_q       <= Base_address;
                SRAM_address <= Base_address;
                word_cnt     <= 17'd1;
                pix_cnt      <= '0;
                phase        <= 1'b0;
                residue      <= '0;
                Underflow    <= 1'b0;
            end else if (issue) begin
                SRAM_address <= base_q + 18'(word_cnt);
                word_cnt     <= word_cnt + 17'd1;
            end
            if (serve) begin
                pix_cnt <= pix_cnt + 17'd1;
                if (!have_words) begin
                    {Pixel_R, Pixel_G, Pixel_B} <= '0;
                    Underflow                   <= 1'b1;
                end else if (!phase) begin
                    {Pixel_R, Pixel_G} <= w0;
                    Pixel_B            <= w1[15:8];
                    residue            <= w1[7:0];
                    phase              <= 1'b1;
                end else begin
                    Pixel_R            <= residue;
                    {Pixel_G, Pixel_B} <= w0;
                    phase              <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_rgb_prefetch.sv
// Randomized bench for vga_rgb_prefetch: an SRAM model with fixed latency and
// a pixel model computed from word-index arithmetic on the packed frame.
module tb_vga_rgb_prefetch;

    localparam int L      = 2;
    localparam int DEPTH  = 8;
    localparam int NPIX   = 800;
    localparam int NWORDS = NPIX * 3 / 2;

    logic        Clock_50 = 1'b0;
    logic        Reset, Start, Pixel_req;
    logic [17:0] Base_address, SRAM_address;
    logic [15:0] SRAM_read_data;
    logic        SRAM_we_n, Pixel_valid, Busy, Frame_done, Underflow;
    logic [7:0]  Pixel_R, Pixel_G, Pixel_B;

    always #5 Clock_50 = ~Clock_50;

    vga_rgb_prefetch #(
        .SRAM_LATENCY (L),
        .FIFO_DEPTH   (DEPTH),
        .FRAME_PIXELS (NPIX)
    ) dut (
        .Clock_50       (Clock_50),
        .Reset          (Reset),
        .Start          (Start),
        .Base_address   (Base_address),
        .SRAM_read_data (SRAM_read_data),
        .SRAM_address   (SRAM_address),
        .SRAM_we_n      (SRAM_we_n),
        .Pixel_req      (Pixel_req),
        .Pixel_valid    (Pixel_valid),
        .Pixel_R        (Pixel_R),
        .Pixel_G        (Pixel_G),
        .Pixel_B        (Pixel_B),
        .Busy           (Busy),
        .Frame_done     (Frame_done),
        .Underflow      (Underflow)
    );

    // SRAM contents: mode 0 is word = address[15:0], mode 1 a scrambled pattern.
    int          mem_mode = 0;
    logic [17:0] apipe [L];

    function automatic logic [15:0] mem_word(logic [17:0] a, int mode);
        logic [15:0] s;
        if (mode == 0) return a[15:0];
        s = a[15:0] * 16'd40503;
        return s ^ {a[17:16], 14'h01A5};
    endfunction

    always @(posedge Clock_50) begin
        apipe[0] <= SRAM_address;
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign SRAM_read_data = mem_word(apipe[L-1], mem_mode);

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Address-bus and pulse monitors.
    bit          mon_on = 1'b0;
    logic [17:0] mon_last;
    int          mon_issues;
    int          valid_cnt = 0;
    int          done_cnt  = 0;

    always @(negedge Clock_50) begin
        logic [17:0] nxt;
        if (Pixel_valid) valid_cnt++;
        if (Frame_done)  done_cnt++;
        if (mon_on && SRAM_address != mon_last) begin
            nxt = mon_last + 18'd1;
            check("addr_seq", SRAM_address, nxt);
            mon_last = SRAM_address;
            mon_issues++;
        end
    end

    // Frame model state.
    logic [17:0] m_base;
    int          m_served, m_pix, v0, d0;
    bit          m_uf;

    task automatic tick();
        @(posedge Clock_50);
        #1;
    endtask

    function automatic logic [15:0] word_at(int k);
        logic [17:0] a;
        a = m_base + 18'(k);
        return mem_word(a, mem_mode);
    endfunction

    task automatic start_frame(logic [17:0] base, int mode);
        mon_on       = 1'b0;
        mem_mode     = mode;
        Base_address = base;
        Start        = 1'b1;
        tick();
        Start        = 1'b0;
        Base_address = 18'($urandom);
        check("busy_after_start", Busy, 1);
        check("first_addr", SRAM_address, base);
        check("uf_after_start", Underflow, 0);
        mon_last   = base;
        mon_issues = 1;
        mon_on     = 1'b1;
        m_base     = base;
        m_served   = 0;
        m_pix      = 0;
        m_uf       = 1'b0;
        v0         = valid_cnt;
        d0         = done_cnt;
    endtask

    task automatic pixel(bit expect_uf, output logic [23:0] rgb);
        logic [15:0] a, b;
        logic [23:0] exp;
        int          g;
        g = (m_served / 2) * 3;
        if (expect_uf) begin
            exp  = '0;
            m_uf = 1'b1;
        end else if (m_served % 2 == 0) begin
            a   = word_at(g);
            b   = word_at(g + 1);
            exp = {a, b[15:8]};
            m_served++;
        end else begin
            a   = word_at(g + 1);
            b   = word_at(g + 2);
            exp = {a[7:0], b};
            m_served++;
        end
        Pixel_req = 1'b1;
        tick();
        Pixel_req = 1'b0;
        rgb = {Pixel_R, Pixel_G, Pixel_B};
        m_pix++;
        check("pix_valid", Pixel_valid, 1);
        check("pix_rgb", rgb, exp);
        check("pix_underflow", Underflow, m_uf);
        if (m_pix == NPIX) begin
            check("frame_done", Frame_done, 1);
            check("busy_end", Busy, 0);
        end else begin
            check("frame_done_early", Frame_done, 0);
        end
    endtask

    task automatic run_pixels(int n, int gmin, int gmax, bit poke_start, int stop_issues);
        logic [23:0] rgb;
        int          gap;
        for (int i = 0; i < n; i++) begin
            if (stop_issues > 0 && mon_issues >= stop_issues) break;
            pixel(1'b0, rgb);
            gap = $urandom_range(gmax, gmin);
            for (int j = 0; j < gap - 1; j++) begin
                if (poke_start && i < n - 1 && i % 97 == 5 && j == 0) begin
                    Base_address = 18'($urandom);
                    Start        = 1'b1;
                    tick();
                    Start        = 1'b0;
                end else begin
                    tick();
                end
            end
        end
    endtask

    task automatic end_frame();
        logic [17:0] last;
        repeat (3) tick();
        mon_on = 1'b0;
        last   = m_base + 18'(NWORDS - 1);
        check("issue_count", mon_issues, NWORDS);
        check("last_addr", SRAM_address, last);
        check("valid_pulses", valid_cnt - v0, NPIX);
        check("done_pulses", done_cnt - d0, 1);
        check("busy_idle", Busy, 0);
        check("uf_end", Underflow, m_uf);
    endtask

    initial begin
        logic [23:0] rgb;
        logic [17:0] exp_addr;
        Reset        = 1'b1;
        Start        = 1'b0;
        Pixel_req    = 1'b0;
        Base_address = '0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        check("rst_addr", SRAM_address, 0);
        check("rst_we_n", SRAM_we_n, 1);
        check("rst_valid", Pixel_valid, 0);
        check("rst_rgb", {Pixel_R, Pixel_G, Pixel_B}, 0);
        check("rst_busy", Busy, 0);
        check("rst_done", Frame_done, 0);
        check("rst_uf", Underflow, 0);

        // Pixel_req while idle is ignored.
        Pixel_req = 1'b1;
        tick();
        Pixel_req = 1'b0;
        check("idle_req_valid", Pixel_valid, 0);
        check("idle_req_uf", Underflow, 0);

        // Identity image from base 0, one request every two cycles.
        start_frame(18'h0, 0);
        repeat (20) tick();
        pixel(1'b0, rgb); tick(); check("pix0_const", rgb, 24'h000000);
        pixel(1'b0, rgb); tick(); check("pix1_const", rgb, 24'h010002);
        pixel(1'b0, rgb); tick(); check("pix2_const", rgb, 24'h000300);
        run_pixels(NPIX - 3, 2, 2, 1'b0, 0);
        end_frame();

        // Base 0x2EE00 with Start pulsed while busy.
        start_frame(18'h2EE00, 1);
        repeat (20) tick();
        run_pixels(NPIX, 2, 5, 1'b1, 0);
        end_frame();

        // Consumer stalled: reads stop once FIFO plus in-flight reach DEPTH.
        start_frame(18'($urandom), 1);
        repeat (50) tick();
        exp_addr = m_base + 18'(DEPTH - 1);
        check("stall_addr", SRAM_address, exp_addr);
        check("stall_issues", mon_issues, DEPTH);
        run_pixels(NPIX, 2, 4, 1'b0, 0);
        end_frame();

        // Address bus wraps at the top of the 18-bit space.
        start_frame(18'h3FF00, 1);
        repeat (20) tick();
        run_pixels(NPIX, 2, 4, 1'b0, 0);
        end_frame();

        // Request two cycles after Start underflows; the frame still completes.
        start_frame(18'($urandom), 1);
        tick();
        pixel(1'b1, rgb);
        repeat (20) tick();
        run_pixels(NPIX - 1, 2, 4, 1'b0, 0);
        end_frame();

        // Next Start clears Underflow and leftover words are not served.
        start_frame(18'($urandom), 1);
        repeat (20) tick();
        run_pixels(NPIX, 2, 3, 1'b0, 0);
        end_frame();

        // Reset mid-frame after about 1000 words, then restart at once.
        start_frame(18'h0, 0);
        repeat (20) tick();
        run_pixels(NPIX, 2, 2, 1'b0, 1000);
        check("reset_point", (mon_issues >= 1000) ? 1 : 0, 1);
        mon_on = 1'b0;
        Reset  = 1'b1;
        tick();
        Reset  = 1'b0;
        check("midrst_busy", Busy, 0);
        check("midrst_addr", SRAM_address, 0);
        check("midrst_valid", Pixel_valid, 0);
        start_frame(18'h0, 0);
        repeat (20) tick();
        pixel(1'b0, rgb); tick(); check("re_pix0_const", rgb, 24'h000000);
        pixel(1'b0, rgb); tick(); check("re_pix1_const", rgb, 24'h010002);
        pixel(1'b0, rgb); tick(); check("re_pix2_const", rgb, 24'h000300);
        run_pixels(NPIX - 3, 2, 2, 1'b0, 0);
        end_frame();

        // Start in the same cycle as Reset: Reset wins.
        Reset        = 1'b1;
        Start        = 1'b1;
        Base_address = 18'h12345;
        tick();
        Reset = 1'b0;
        Start = 1'b0;
        tick();
        check("rst_start_busy", Busy, 0);
        check("rst_start_addr", SRAM_address, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
